dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- Issue stage in front of the two-lane Execute block of the superscalar core.
- Accepts a decoded instruction pair and checks intra-pair register hazards.
- Drives registered per-lane ALU control to lanes 1 and 2.
- Dependent pairs are split across two cycles and upstream is held meanwhile.

Parameters:
- CNT_W, 16: width of the saturating pair and split statistics counters.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  decode presents a pair.
- in_ready  output  1  scheduler accepts a pair this cycle.
- stall  input  1  downstream hold; freezes scheduler.
- slot_valid_1 / slot_valid_2  input  1  slot contains an instruction.
- rs_1 / rs_2, rt_1 / rt_2, rd_1 / rd_2  input  5  source and destination register indices.
- writes_1 / writes_2  input  1  slot writes rd.
- uses_rt_2  input  1  slot 2 reads rt as an operand (mux flag 0).
- mux_1_flag_1 / mux_1_flag_2  input  2  operand-B select: 0 reg, 1 imm, 2 shamt.
- Alu_function_1 / Alu_function_2  input  4  ALU op.
- issue_valid_1 / issue_valid_2  output  1  lane carries a live instruction this cycle.
- ex_rs_1/2, ex_rt_1/2, ex_rd_1/2  output  5  registered indices per lane.
- ex_writes_1/2  output  1  registered write enable per lane.
- ex_mux_1_flag_1/2  output  2  registered mux select per lane.
- ex_Alu_function_1/2  output  4  registered ALU op per lane.
- pair_count, split_count  output  CNT_W  statistics.

Behaviour:
- Reset, synchronous: state=ISSUE. All ex_* outputs, issue_valid_* and both counters are 0. in_ready = 1 once reset is released.
- in_ready is combinational: (state==ISSUE) && !stall.
- A pair is accepted when in_valid && in_ready.
- Hazard, computed combinationally on the input pair:
  - dep = slot_valid_1 && slot_valid_2 && writes_1 && rd_1!=0 && (rs_2==rd_1 || (uses_rt_2 && rt_2==rd_1) || (writes_2 && rd_2==rd_1)).
  - Register 0 never creates a hazard.
- States:
  - ISSUE, accept with !dep: next edge loads lane 1 from slot 1 and lane 2 from slot 2. issue_valid_n = slot_valid_n. pair_count++ when both slots are valid. Stay in ISSUE.
  - ISSUE, accept with dep: next edge loads lane 1 from slot 1 and sets issue_valid_1=1, issue_valid_2=0. Slot 2 fields are captured in an internal hold register. split_count++. Go to SPLIT.
  - ISSUE, no accept and !stall: next edge issue_valid_1 and issue_valid_2 = 0 (bubble). ex_* fields hold their values.
  - SPLIT, !stall: next edge loads lane 2 from the hold register and sets issue_valid_2=1, issue_valid_1=0. Return to ISSUE. in_ready=0 for the whole SPLIT cycle.
- stall=1: all registers, state and counters hold. No acceptance. issue_valid_* are held, not cleared.
- Latency: accept to issue is 1 cycle. A split pair occupies 2 issue cycles.
- Slot 2 is always issued on lane 2, including when only slot 2 is valid (issue_valid_1=0). Lane 1 never receives slot 2.
- Counters saturate at all-ones and do not wrap.
- Reset during SPLIT: the held slot 2 instruction is discarded and state returns to ISSUE.
- Reset asserted together with in_valid: reset wins and nothing is accepted.

Decomposition:
- Shared package constants:
  - MUX_REG=2'd0, MUX_IMM=2'd1, MUX_SHAMT=2'd2.
  - REG_ZERO=5'd0.
  - State encoding ST_ISSUE=1'b0, ST_SPLIT=1'b1.
- One natural sub-module, hazard_check: purely combinational dep logic, reusable by the forwarding unit.

Test Plan:
- Independent pair {slot1: rd=3, writes; slot2: rs=4, rt=5, uses_rt} → one cycle later both issue_valid=1, ex_rd_1=3, pair_count=1, split_count=0.
- RAW pair {slot1: rd=7, writes; slot2: rs=7} → cycle N+1: lane 1 only, in_ready=0. Cycle N+2: lane 2 only, ex_rs_2=7. split_count=1.
- rd_1=0 with rs_2=0 → no split, both lanes issue together.
- WAW pair {rd_1=9, rd_2=9, both writing} → split.
- stall asserted in SPLIT for 3 cycles → outputs frozen and in_ready=0. Lane 2 issues one cycle after stall drops.
- Reset asserted in SPLIT → next cycle issue_valid_* and counters are 0, in_ready=1, and the held slot 2 is never issued.

Source files
------------

// File: rtl/dual_issue_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dual_issue_scheduler_pkg
// Shared constants and types for the dual-issue scheduler and its hazard
// checker.
//   MUX_*     : operand-B select encodings carried on the ex_mux_1_flag lanes.
//   REG_ZERO  : hard-wired zero register index. It never creates a hazard.
//   state_e   : issue FSM state.
//   lane_t    : the per-lane ALU control bundle. The same type is used for an
//               incoming slot, a registered lane and the split hold register.
// -----------------------------------------------------------------------------
package dual_issue_scheduler_pkg;

  localparam logic [1:0] MUX_REG   = 2'd0;
  localparam logic [1:0] MUX_IMM   = 2'd1;
  localparam logic [1:0] MUX_SHAMT = 2'd2;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       writes;
    logic [1:0] mux_1_flag;
    logic [3:0] alu_function;
  } lane_t;

  localparam lane_t LANE_NONE = '0;

endpackage

// File: rtl/dual_issue_scheduler_hazard_check.sv
// -----------------------------------------------------------------------------
// dual_issue_scheduler_hazard_check
// Purely combinational intra-pair dependency check. Slot 2 depends on slot 1
// when slot 1 writes a non-zero register that slot 2 reads (rs, or rt when rt
// is a real operand) or also writes (WAW). The forwarding unit can reuse it.
// Ports:
//   slot_valid_1/2 : both slots must hold an instruction for a hazard.
//   writes_1/2     : slot writes its rd.
//   uses_rt_2      : slot 2 reads rt as a register operand.
//   rd_1           : slot 1 destination.
//   rs_2/rt_2/rd_2 : slot 2 sources and destination.
//   dep            : slot 2 must not issue in the same cycle as slot 1.
// -----------------------------------------------------------------------------
module dual_issue_scheduler_hazard_check
  import dual_issue_scheduler_pkg::*;
(
  input  logic       slot_valid_1,
  input  logic       slot_valid_2,
  input  logic       writes_1,
  input  logic       writes_2,
  input  logic       uses_rt_2,
  input  logic [4:0] rd_1,
  input  logic [4:0] rs_2,
  input  logic [4:0] rt_2,
  input  logic [4:0] rd_2,
  output logic       dep
);

  logic producer;
  logic raw_rs;
  logic raw_rt;
  logic waw;

  // Slot 1 can only cause a hazard if it actually writes a real register.
  assign producer = slot_valid_1 && slot_valid_2 && writes_1 && (rd_1 != REG_ZERO);
  assign raw_rs   = (rs_2 == rd_1);
  assign raw_rt   = uses_rt_2 && (rt_2 == rd_1);
  assign waw      = writes_2 && (rd_2 == rd_1);

  assign dep = producer && (raw_rs || raw_rt || waw);

endmodule

// File: rtl/dual_issue_scheduler.sv
// -----------------------------------------------------------------------------
// dual_issue_scheduler
// Issue stage in front of the two-lane Execute block. A decoded pair is
// accepted when in_valid && in_ready and appears on the registered lane
// outputs one cycle later. Slot 1 always goes to lane 1, slot 2 always to
// lane 2. A dependent pair is split: lane 1 issues first, slot 2 is parked in
// a hold register and issues on lane 2 in the following cycle. in_ready is
// low during that cycle so upstream holds. stall freezes everything.
// Ports:
//   clk, reset             : core clock, synchronous active-high reset.
//   in_valid / in_ready    : pair handshake with decode.
//   stall                  : downstream hold, freezes all state.
//   slot_valid_n, rs_n, rt_n, rd_n, writes_n, mux_1_flag_n, Alu_function_n
//                          : decoded slot fields.
//   uses_rt_2              : slot 2 reads rt as a register operand.
//   issue_valid_n          : lane n carries a live instruction.
//   ex_*_n                 : registered lane n ALU control.
//   pair_count             : saturating count of dual issues of two valid slots.
//   split_count            : saturating count of split pairs.
// -----------------------------------------------------------------------------
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             slot_valid_1,
  input  logic             slot_valid_2,
  input  logic [4:0]       rs_1,
  input  logic [4:0]       rs_2,
  input  logic [4:0]       rt_1,
  input  logic [4:0]       rt_2,
  input  logic [4:0]       rd_1,
  input  logic [4:0]       rd_2,
  input  logic             writes_1,
  input  logic             writes_2,
  input  logic             uses_rt_2,
  input  logic [1:0]       mux_1_flag_1,
  input  logic [1:0]       mux_1_flag_2,
  input  logic [3:0]       Alu_function_1,
  input  logic [3:0]       Alu_function_2,
  output logic             issue_valid_1,
  output logic             issue_valid_2,
  output logic [4:0]       ex_rs_1,
  output logic [4:0]       ex_rs_2,
  output logic [4:0]       ex_rt_1,
  output logic [4:0]       ex_rt_2,
  output logic [4:0]       ex_rd_1,
  output logic [4:0]       ex_rd_2,
  output logic             ex_writes_1,
  output logic             ex_writes_2,
  output logic [1:0]       ex_mux_1_flag_1,
  output logic [1:0]       ex_mux_1_flag_2,
  output logic [3:0]       ex_Alu_function_1,
  output logic [3:0]       ex_Alu_function_2,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] split_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  lane_t            lane_1_q, lane_1_d;
  lane_t            lane_2_q, lane_2_d;
  lane_t            hold_q, hold_d;
  logic             issue_valid_1_q, issue_valid_1_d;
  logic             issue_valid_2_q, issue_valid_2_d;
  logic [CNT_W-1:0] pair_count_q, pair_count_d;
  logic [CNT_W-1:0] split_count_q, split_count_d;

  lane_t slot_1;
  lane_t slot_2;
  logic  dep;
  logic  accept;

  always_comb begin
    slot_1.rs           = rs_1;
    slot_1.rt           = rt_1;
    slot_1.rd           = rd_1;
    slot_1.writes       = writes_1;
    slot_1.mux_1_flag   = mux_1_flag_1;
    slot_1.alu_function = Alu_function_1;
    slot_2.rs           = rs_2;
    slot_2.rt           = rt_2;
    slot_2.rd           = rd_2;
    slot_2.writes       = writes_2;
    slot_2.mux_1_flag   = mux_1_flag_2;
    slot_2.alu_function = Alu_function_2;
  end

  dual_issue_scheduler_hazard_check u_hazard_check (
    .slot_valid_1 (slot_valid_1),
    .slot_valid_2 (slot_valid_2),
    .writes_1     (writes_1),
    .writes_2     (writes_2),
    .uses_rt_2    (uses_rt_2),
    .rd_1         (rd_1),
    .rs_2         (rs_2),
    .rt_2         (rt_2),
    .rd_2         (rd_2),
    .dep          (dep)
  );

  assign in_ready = (state_q == ST_ISSUE) && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every *_d gets a hold default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d         = state_q;
    lane_1_d        = lane_1_q;
    lane_2_d        = lane_2_q;
    hold_d          = hold_q;
    issue_valid_1_d = issue_valid_1_q;
    issue_valid_2_d = issue_valid_2_q;
    pair_count_d    = pair_count_q;
    split_count_d   = split_count_q;

    // With stall high the defaults above freeze everything, including the
    // issue_valid flags.
    if (!stall) begin
      unique case (state_q)
        ST_ISSUE: begin
          if (accept) begin
            lane_1_d = slot_1;
            if (dep) begin
              // Lane 2 fields keep their old contents; only the valid drops.
              issue_valid_1_d = 1'b1;
              issue_valid_2_d = 1'b0;
              hold_d          = slot_2;
              state_d         = ST_SPLIT;
              if (split_count_q != CNT_MAX) split_count_d = split_count_q + CNT_W'(1);
            end else begin
              lane_2_d        = slot_2;
              issue_valid_1_d = slot_valid_1;
              issue_valid_2_d = slot_valid_2;
              if (slot_valid_1 && slot_valid_2 && (pair_count_q != CNT_MAX)) begin
                pair_count_d = pair_count_q + CNT_W'(1);
              end
            end
          end else begin
            // Bubble: fields hold, only the valids drop.
            issue_valid_1_d = 1'b0;
            issue_valid_2_d = 1'b0;
          end
        end
        ST_SPLIT: begin
          lane_2_d        = hold_q;
          issue_valid_1_d = 1'b0;
          issue_valid_2_d = 1'b1;
          state_d         = ST_ISSUE;
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // The hold register is cleared too: a split interrupted by reset must leave
  // nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_ISSUE;
      lane_1_q        <= LANE_NONE;
      lane_2_q        <= LANE_NONE;
      hold_q          <= LANE_NONE;
      issue_valid_1_q <= 1'b0;
      issue_valid_2_q <= 1'b0;
      pair_count_q    <= '0;
      split_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      lane_1_q        <= lane_1_d;
      lane_2_q        <= lane_2_d;
      hold_q          <= hold_d;
      issue_valid_1_q <= issue_valid_1_d;
      issue_valid_2_q <= issue_valid_2_d;
      pair_count_q    <= pair_count_d;
      split_count_q   <= split_count_d;
    end
  end

  assign issue_valid_1     = issue_valid_1_q;
  assign issue_valid_2     = issue_valid_2_q;
  assign ex_rs_1           = lane_1_q.rs;
  assign ex_rt_1           = lane_1_q.rt;
  assign ex_rd_1           = lane_1_q.rd;
  assign ex_writes_1       = lane_1_q.writes;
  assign ex_mux_1_flag_1   = lane_1_q.mux_1_flag;
  assign ex_Alu_function_1 = lane_1_q.alu_function;
  assign ex_rs_2           = lane_2_q.rs;
  assign ex_rt_2           = lane_2_q.rt;
  assign ex_rd_2           = lane_2_q.rd;
  assign ex_writes_2       = lane_2_q.writes;
  assign ex_mux_1_flag_2   = lane_2_q.mux_1_flag;
  assign ex_Alu_function_2 = lane_2_q.alu_function;
  assign pair_count        = pair_count_q;
  assign split_count       = split_count_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_scheduler
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (a queue of parked slot-2 instructions plus the
// expected lane contents) is advanced on every rising edge; one compare
// process checks every DUT output against it on every falling edge. Small
// counters (CNT_W=4) make saturation reachable.
// -----------------------------------------------------------------------------
module tb_dual_issue_scheduler;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       w;
    logic [1:0] mux;
    logic [3:0] alu;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic stall = 1'b0;
  logic slot_valid_1 = 1'b0, slot_valid_2 = 1'b0;
  logic [4:0] rs_1 = '0, rs_2 = '0, rt_1 = '0, rt_2 = '0, rd_1 = '0, rd_2 = '0;
  logic writes_1 = 1'b0, writes_2 = 1'b0, uses_rt_2 = 1'b0;
  logic [1:0] mux_1_flag_1 = '0, mux_1_flag_2 = '0;
  logic [3:0] Alu_function_1 = '0, Alu_function_2 = '0;

  logic in_ready;
  logic issue_valid_1, issue_valid_2;
  logic [4:0] ex_rs_1, ex_rs_2, ex_rt_1, ex_rt_2, ex_rd_1, ex_rd_2;
  logic ex_writes_1, ex_writes_2;
  logic [1:0] ex_mux_1_flag_1, ex_mux_1_flag_2;
  logic [3:0] ex_Alu_function_1, ex_Alu_function_2;
  logic [CNT_W-1:0] pair_count, split_count;

  dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .stall             (stall),
    .slot_valid_1      (slot_valid_1),
    .slot_valid_2      (slot_valid_2),
    .rs_1              (rs_1),
    .rs_2              (rs_2),
    .rt_1              (rt_1),
    .rt_2              (rt_2),
    .rd_1              (rd_1),
    .rd_2              (rd_2),
    .writes_1          (writes_1),
    .writes_2          (writes_2),
    .uses_rt_2         (uses_rt_2),
    .mux_1_flag_1      (mux_1_flag_1),
    .mux_1_flag_2      (mux_1_flag_2),
    .Alu_function_1    (Alu_function_1),
    .Alu_function_2    (Alu_function_2),
    .issue_valid_1     (issue_valid_1),
    .issue_valid_2     (issue_valid_2),
    .ex_rs_1           (ex_rs_1),
    .ex_rs_2           (ex_rs_2),
    .ex_rt_1           (ex_rt_1),
    .ex_rt_2           (ex_rt_2),
    .ex_rd_1           (ex_rd_1),
    .ex_rd_2           (ex_rd_2),
    .ex_writes_1       (ex_writes_1),
    .ex_writes_2       (ex_writes_2),
    .ex_mux_1_flag_1   (ex_mux_1_flag_1),
    .ex_mux_1_flag_2   (ex_mux_1_flag_2),
    .ex_Alu_function_1 (ex_Alu_function_1),
    .ex_Alu_function_2 (ex_Alu_function_2),
    .pair_count        (pair_count),
    .split_count       (split_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  ins_t m_l1 = '0;
  ins_t m_l2 = '0;
  bit   m_v1 = 1'b0;
  bit   m_v2 = 1'b0;
  int   m_pairs = 0;
  int   m_splits = 0;
  ins_t m_held[$];

  function automatic ins_t cur_slot1();
    return {rs_1, rt_1, rd_1, writes_1, mux_1_flag_1, Alu_function_1};
  endfunction

  function automatic ins_t cur_slot2();
    return {rs_2, rt_2, rd_2, writes_2, mux_1_flag_2, Alu_function_2};
  endfunction

  function automatic bit pair_dep();
    if (!(slot_valid_1 && slot_valid_2 && writes_1) || rd_1 == 5'd0) return 1'b0;
    return (rs_2 == rd_1) || (uses_rt_2 && rt_2 == rd_1) || (writes_2 && rd_2 == rd_1);
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_l1 = '0; m_l2 = '0; m_v1 = 0; m_v2 = 0;
      m_pairs = 0; m_splits = 0;
      m_held.delete();
    end else if (!stall) begin
      if (m_held.size() != 0) begin
        m_l2 = m_held.pop_front();
        m_v1 = 0; m_v2 = 1;
      end else if (in_valid) begin
        m_l1 = cur_slot1();
        if (pair_dep()) begin
          m_v1 = 1; m_v2 = 0;
          m_held.push_back(cur_slot2());
          m_splits = sat_inc(m_splits);
        end else begin
          m_l2 = cur_slot2();
          m_v1 = slot_valid_1; m_v2 = slot_valid_2;
          if (slot_valid_1 && slot_valid_2) m_pairs = sat_inc(m_pairs);
        end
      end else begin
        m_v1 = 0; m_v2 = 0;
      end
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (cmp_en) begin
      check("issue_valid_1", issue_valid_1, m_v1);
      check("issue_valid_2", issue_valid_2, m_v2);
      check("lane1", {ex_rs_1, ex_rt_1, ex_rd_1, ex_writes_1, ex_mux_1_flag_1, ex_Alu_function_1}, m_l1);
      check("lane2", {ex_rs_2, ex_rt_2, ex_rd_2, ex_writes_2, ex_mux_1_flag_2, ex_Alu_function_2}, m_l2);
      check("pair_count", pair_count, m_pairs);
      check("split_count", split_count, m_splits);
      if (!reset) check("in_ready", in_ready, (m_held.size() == 0) && !stall);
    end
  end

  // ---------------------------------------------------------------- drive
  function automatic ins_t mk(input int rs, rt, rd, w, mux, alu);
    ins_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.w = 1'(w); r.mux = 2'(mux); r.alu = 4'(alu);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    in_valid = 0; slot_valid_1 = 0; slot_valid_2 = 0;
  endtask

  task automatic set_pair(input bit v1, input bit v2, input ins_t a, input ins_t b, input bit urt);
    in_valid = 1; slot_valid_1 = v1; slot_valid_2 = v2; uses_rt_2 = urt;
    rs_1 = a.rs; rt_1 = a.rt; rd_1 = a.rd; writes_1 = a.w;
    mux_1_flag_1 = a.mux; Alu_function_1 = a.alu;
    rs_2 = b.rs; rt_2 = b.rt; rd_2 = b.rd; writes_2 = b.w;
    mux_1_flag_2 = b.mux; Alu_function_2 = b.alu;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    reset = 1;
    tick();
    tick();
    reset = 0;
    cmp_en = 1;

    // Reset state.
    @(negedge clk);
    check("rst issue_valid_1", issue_valid_1, 0);
    check("rst pair_count", pair_count, 0);
    check("rst in_ready", in_ready, 1);

    // Independent pair.
    tick();
    set_pair(1, 1, mk(1, 2, 3, 1, 0, 1), mk(4, 5, 6, 1, 0, 2), 1);
    tick();
    set_idle();
    @(negedge clk);
    check("ind issue_valid_1", issue_valid_1, 1);
    check("ind issue_valid_2", issue_valid_2, 1);
    check("ind ex_rd_1", ex_rd_1, 3);
    check("ind pair_count", pair_count, 1);
    check("ind split_count", split_count, 0);

    // RAW pair: split over two cycles.
    tick();
    set_pair(1, 1, mk(1, 2, 7, 1, 1, 3), mk(7, 8, 10, 1, 0, 4), 0);
    tick();
    set_idle();
    @(negedge clk);
    check("raw c1 issue_valid_1", issue_valid_1, 1);
    check("raw c1 issue_valid_2", issue_valid_2, 0);
    check("raw c1 in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("raw c2 issue_valid_1", issue_valid_1, 0);
    check("raw c2 issue_valid_2", issue_valid_2, 1);
    check("raw c2 ex_rs_2", ex_rs_2, 7);
    check("raw split_count", split_count, 1);

    // rd_1 = 0 never creates a hazard.
    tick();
    set_pair(1, 1, mk(1, 2, 0, 1, 2, 5), mk(0, 0, 0, 1, 0, 6), 1);
    tick();
    set_idle();
    @(negedge clk);
    check("r0 issue_valid_2", issue_valid_2, 1);
    check("r0 pair_count", pair_count, 2);
    check("r0 split_count", split_count, 1);

    // WAW pair splits.
    tick();
    set_pair(1, 1, mk(1, 2, 9, 1, 0, 7), mk(3, 4, 9, 1, 1, 8), 0);
    tick();
    set_idle();
    @(negedge clk);
    check("waw issue_valid_2", issue_valid_2, 0);
    check("waw split_count", split_count, 2);
    tick();
    @(negedge clk);
    check("waw lane2 ex_rd_2", ex_rd_2, 9);

    // Stall for 3 cycles while in SPLIT.
    tick();
    set_pair(1, 1, mk(1, 2, 12, 1, 0, 9), mk(12, 3, 4, 0, 0, 10), 0);
    tick();
    set_idle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall issue_valid_1", issue_valid_1, 1);
      check("stall issue_valid_2", issue_valid_2, 0);
      check("stall in_ready", in_ready, 0);
      tick();
    end
    stall = 0;
    tick();
    @(negedge clk);
    check("unstall issue_valid_2", issue_valid_2, 1);
    check("unstall ex_rs_2", ex_rs_2, 12);
    check("unstall split_count", split_count, 3);

    // Reset in SPLIT, together with in_valid: held slot 2 is discarded.
    tick();
    set_pair(1, 1, mk(1, 2, 11, 1, 0, 11), mk(11, 5, 6, 1, 0, 12), 0);
    tick();
    reset = 1;
    set_pair(1, 1, mk(1, 2, 3, 1, 0, 1), mk(4, 5, 6, 1, 0, 2), 0);
    tick();
    reset = 0;
    set_idle();
    @(negedge clk);
    check("rsplit issue_valid_1", issue_valid_1, 0);
    check("rsplit issue_valid_2", issue_valid_2, 0);
    check("rsplit pair_count", pair_count, 0);
    check("rsplit split_count", split_count, 0);
    check("rsplit in_ready", in_ready, 1);
    tick();
    @(negedge clk);
    check("rsplit no lane2", issue_valid_2, 0);

    // Randomized traffic with hazard-heavy register indices.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset        = ($urandom_range(0, 299) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      slot_valid_1 = ($urandom_range(0, 7) != 0);
      slot_valid_2 = ($urandom_range(0, 7) != 0);
      rs_1 = 5'($urandom_range(0, 7)); rt_1 = 5'($urandom_range(0, 7));
      rd_1 = 5'($urandom_range(0, 7)); rs_2 = 5'($urandom_range(0, 7));
      rt_2 = 5'($urandom_range(0, 7)); rd_2 = 5'($urandom_range(0, 7));
      writes_1 = 1'($urandom_range(0, 1)); writes_2 = 1'($urandom_range(0, 1));
      uses_rt_2 = 1'($urandom_range(0, 1));
      mux_1_flag_1 = 2'($urandom_range(0, 2)); mux_1_flag_2 = 2'($urandom_range(0, 2));
      Alu_function_1 = 4'($urandom_range(0, 15)); Alu_function_2 = 4'($urandom_range(0, 15));
    end
    tick();
    reset = 0;
    stall = 0;
    set_idle();
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
